viterbi_dec: RTL
================

# viterbi_dec

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators 7,5 octal) produced by the team's convolutional encoder. It sits at the receive end of the link, takes one 2-bit code symbol per accepted cycle, and emits one decoded data bit per accepted symbol after a fixed decision depth. Survivors use register exchange, and path metrics are renormalised every step.

## Interface
- TB_DEPTH, default 15: decision depth D in symbols. Survivor register width; range 4..32.
- METRIC_W, default 4: path-metric width; must be ≥ 3.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- y_in  input  2  received symbol: y_in[1] = x^x[n-1]^x[n-2], y_in[0] = x^x[n-2].
- in_valid  input  1  y_in accepted on a rising clk when high.
- x_out  output  1  decoded bit, registered.
- out_valid  output  1  x_out valid this cycle; single-cycle strobe per accepted symbol once primed.

## Operation
- Trellis has 4 states.
  - State s = {x[n-2], x[n-1]}; s[0] is the most recent bit.
  - Transition on input a: s → {s[0], a}.
  - Expected symbol from state s on input a is {a^s[0]^s[1], a^s[1]}.
- Branch metric BM = Hamming distance (0..2) between y_in and the expected symbol.
- Add-compare-select (ACS) for each next state ns:
  - Predecessors are p0 = {0, ns[1]} and p1 = {1, ns[1]}, with input a = ns[0].
  - Candidate c = PM[p] + BM(p, a) for each predecessor.
  - Select p0 if c0 ≤ c1; ties go to p0.
- Survivors: surv[ns] ← {surv[p_sel][D-2:0], ns[0]}. Each survivor shifts left and appends the decided bit at the LSB.
- Normalisation: PM[ns] ← c_sel − min over the four c_sel values. The minimum new metric is therefore always 0.
- Best state is the lowest new PM; ties go to the lowest state index.
- Output bit x_out ← new surv[best][D-1].
- Symbol counter increments per accepted symbol and saturates at D.
- Primed: out_valid ← 1 for an accepted symbol when the counter, including that symbol, is ≥ D. Otherwise out_valid ← 0.
- in_valid low: metrics, survivors, counter and x_out hold; out_valid ← 0.
- Metric bound: with the reset bias, the pre-normalisation maximum is 6, so METRIC_W = 3 never overflows. No saturation logic is needed.
- Stream tail: the last D−1 bits come out only if the sender follows the data with two zero tail bits plus further symbols. This block has no flush mechanism.

## Timing
- Reset values: PM = {0, 4, 4, 4} for states 0..3; all survivors 0; counter 0; x_out 0; out_valid 0.
- Reset is asynchronous. Asserting it mid-stream clears state and drops out_valid immediately, without waiting for a clock edge. After release, D new accepted symbols are needed before the next out_valid.
- One symbol per clock is sustained; ACS completes in a single cycle with no back-pressure.
- Latency: the bit carried by symbol k, counted from 1 after reset, appears on x_out with out_valid in the cycle after symbol k+D−1 is accepted.
- First out_valid follows the rising edge that accepts symbol D (the 15th at default).
- Idle cycles between accepted symbols delay outputs but never change their values.

## Test plan
- Reset: assert reset asynchronously mid-cycle.
  - Required: x_out = 0 and out_valid = 0 immediately; internal PM = {0,4,4,4}.
- Error-free stream (D = 15):
  - Stimulus: data 1,0,1,1,0,0 then zeros, encoded as 11,10,00,01,01,11,00,00,... on consecutive cycles.
  - Required: first out_valid after the 15th symbol; x_out sequence 1,0,1,1,0,0,0,...
- Single error: same stream with symbol 3 flipped to 10.
  - Required: identical x_out sequence, proving the error is corrected.
- Gapped input: same stream with in_valid low for 1–3 random cycles between symbols.
  - Required: identical x_out values; out_valid only on cycles following accepted symbols.
- All-zero stream: 40 symbols of 00.
  - Required: x_out = 0 on every strobe; state-0 metric stays 0 throughout.
- Reset mid-stream: reset after 20 symbols, then restart the error-free stream.
  - Required: no out_valid until 15 new symbols are accepted; output matches the error-free scenario exactly.

Source files
------------

// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Four-state ACS with register-exchange survivors and per-step metric renormalisation.
module viterbi_dec #(
  parameter int TB_DEPTH = 15,
  parameter int METRIC_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] y_in,
  input  logic       in_valid,
  output logic       x_out,
  output logic       out_valid
);

  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(TB_DEPTH);

  // Handshake: y_in is consumed on every rising clk with in_valid high (no back-pressure);
  // out_valid is a one-cycle strobe following each accepted symbol once D symbols have been seen.

  logic [METRIC_W-1:0] pm        [4];
  logic [TB_DEPTH-1:0] surv      [4];
  logic [CNT_W-1:0]    cnt;

  logic [METRIC_W-1:0] c0        [4];
  logic [METRIC_W-1:0] c1        [4];
  logic [3:0]          sel;
  logic [METRIC_W-1:0] cand_sel  [4];
  logic [METRIC_W-1:0] pm_next   [4];
  logic [TB_DEPTH-1:0] surv_next [4];
  logic [METRIC_W-1:0] min_c;
  logic [1:0]          best;

  // Hamming distance between y and the symbol emitted leaving state p on input a.
  function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic a,
                                                input logic [1:0] y);
    logic [1:0] expct;
    logic [1:0] d;
    expct = {a ^ p[0] ^ p[1], a ^ p[1]};
    d     = expct ^ y;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  always_comb begin : acs
    logic [1:0] ns;
    logic [1:0] p0;
    logic [1:0] p1;
    ns    = '0;
    p0    = '0;
    p1    = '0;
    min_c = '0;
    best  = '0;
    for (int i = 0; i < 4; i++) begin
      ns           = 2'(i);
      p0           = {1'b0, ns[1]};
      p1           = {1'b1, ns[1]};
      c0[i]        = pm[p0] + METRIC_W'(branch_metric(p0, ns[0], y_in));
      c1[i]        = pm[p1] + METRIC_W'(branch_metric(p1, ns[0], y_in));
      sel[i]       = (c1[i] < c0[i]);
      cand_sel[i]  = sel[i] ? c1[i] : c0[i];
      surv_next[i] = sel[i] ? {surv[p1][TB_DEPTH-2:0], ns[0]}
                            : {surv[p0][TB_DEPTH-2:0], ns[0]};
    end
    min_c = cand_sel[0];
    for (int i = 1; i < 4; i++) begin
      if (cand_sel[i] < min_c) min_c = cand_sel[i];
    end
    // Descending scan so the lowest index holding the minimum wins ties.
    for (int i = 3; i >= 0; i--) begin
      if (cand_sel[i] == min_c) best = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      pm_next[i] = cand_sel[i] - min_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Bias off-zero states so decoding starts from the encoder's known all-zero state.
      pm[0] <= '0;
      pm[1] <= METRIC_W'(4);
      pm[2] <= METRIC_W'(4);
      pm[3] <= METRIC_W'(4);
      for (int i = 0; i < 4; i++) surv[i] <= '0;
      cnt       <= '0;
      x_out     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= pm_next[i];
        surv[i] <= surv_next[i];
      end
      if (cnt != DEPTH) cnt <= cnt + 1'b1;
      x_out     <= surv_next[best][TB_DEPTH-1];
      out_valid <= (cnt >= DEPTH - 1'b1);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
